gpr_wb_arbiter: RTL
===================

GPR_WB_ARBITER -- requirements
Module: gpr_wb_arbiter

Interface
REQ-001 Parameter DATA_W, default 8, register data width.
REQ-002 Parameter ADDR_W, default 3, register address width; register count NREG = 2**ADDR_W (8).
REQ-003 Port list, one per line, in this order:
- clk  in  1  single clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- alu_wb_valid  in  1  ALU writeback request.
- alu_wb_dest  in  ADDR_W  ALU destination register.
- alu_wb_data  in  DATA_W  ALU result.
- alu_wb_ready  out  1  ALU request accepted this cycle.
- mem_wb_valid  in  1  load writeback request.
- mem_wb_dest  in  ADDR_W  load destination register.
- mem_wb_data  in  DATA_W  load data.
- mem_wb_ready  out  1  load request accepted this cycle.
- mark_en  in  1  issue stage reserves a destination.
- mark_addr  in  ADDR_W  register to reserve.
- flush  in  1  synchronous clear of all reservations.
- chk_addr_1  in  ADDR_W  operand 1 hazard query.
- chk_addr_2  in  ADDR_W  operand 2 hazard query.
- hazard_stall  out  1  either queried register is reserved.
- reg_write_en  out  1  GPR write-port enable.
- reg_write_dest  out  ADDR_W  GPR write-port address.
- reg_write_data  out  DATA_W  GPR write-port data.
- wb_unexpected  out  1  sticky error flag.

Function
REQ-004 The block SHALL be the sole driver of the single GPR write port, shared between the ALU and load requesters.
REQ-005 A handshake SHALL complete in a cycle where valid and ready are both high; ready is combinational from the valids and the priority pointer.
REQ-006 At most one ready SHALL be high per cycle; a lone valid requester SHALL be granted in the same cycle.
REQ-007 When both requesters are valid, the requester named by the priority pointer SHALL be granted; the other holds its request stable until granted.
REQ-008 The priority pointer SHALL reset to ALU and, after every grant, point to the requester not granted (round-robin).
REQ-009 Dest and data of a grant at edge N SHALL be registered; during cycle N+1, reg_write_en=1 with that dest and data (latency one cycle).
REQ-010 With no grant at edge N, reg_write_en SHALL be 0 during cycle N+1; dest and data hold their previous values.
REQ-011 Scoreboard: one busy bit per register. mark_en sets busy[mark_addr] at the edge; a cycle with reg_write_en=1 clears busy[reg_write_dest] at the edge.
REQ-012 If a set and a clear hit the same register at the same edge, set SHALL win.
REQ-013 flush SHALL clear all busy bits at the edge, overriding same-edge marks; an already-registered write SHALL still drive the port.
REQ-014 hazard_stall SHALL be combinational: busy[chk_addr_1] OR busy[chk_addr_2]; it reflects state only, with no same-cycle mark or clear bypass.
REQ-015 wb_unexpected SHALL set when reg_write_en=1 and busy[reg_write_dest]=0 (flush-cleared, never marked, or duplicate write). It stays set until reset.
REQ-016 Marking an already-busy register SHALL leave it busy; no count is kept, and the first completing write clears it.
REQ-017 Both requesters targeting the same dest SHALL be serialised by REQ-007; the later write lands last.

Reset
REQ-018 While rst_n=0: reg_write_en=0, reg_write_dest=0, reg_write_data=0, all busy bits 0, pointer=ALU, wb_unexpected=0, and both readys 0, regardless of clk.
REQ-019 Reset asserted mid-operation SHALL drop any registered, not-yet-written grant; the requester must re-present it.
REQ-020 The first grant SHALL occur at the first rising edge with rst_n=1.

Verification
REQ-021 Bench SHALL cover these scenarios:
- Lone ALU: alu valid, dest 3, data 0x5A -> alu_wb_ready=1 same cycle; next cycle reg_write_en=1, dest 3, data 0x5A.
- Contention: both valid for 4 cycles, dest 1 and 2 -> grants ALU, MEM, ALU, MEM; one port write per cycle.
- Scoreboard: mark 4; query chk_addr_1=4 -> hazard_stall=1; after the write to 4 lands -> hazard_stall=0 on the next cycle.
- Set-beats-clear: mark 5 on the same edge a write to 5 lands -> busy[5] remains 1, wb_unexpected stays 0.
- Flush and error: mark 6, flush, then write 6 -> busy[6]=0 and wb_unexpected=1 held until rst_n=0.
- Async reset: drop rst_n between edges with a grant pending -> outputs zero immediately; no write occurs after release.

Source files
------------

// File: rtl/gpr_wb_arbiter.sv
// Writeback arbiter for the single GPR write port: round-robin between ALU and load
// requesters, with a per-register busy scoreboard for issue-stage hazard checks.
module gpr_wb_arbiter #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              alu_wb_valid,
  input  logic [ADDR_W-1:0] alu_wb_dest,
  input  logic [DATA_W-1:0] alu_wb_data,
  output logic              alu_wb_ready,
  input  logic              mem_wb_valid,
  input  logic [ADDR_W-1:0] mem_wb_dest,
  input  logic [DATA_W-1:0] mem_wb_data,
  output logic              mem_wb_ready,
  input  logic              mark_en,
  input  logic [ADDR_W-1:0] mark_addr,
  input  logic              flush,
  input  logic [ADDR_W-1:0] chk_addr_1,
  input  logic [ADDR_W-1:0] chk_addr_2,
  output logic              hazard_stall,
  output logic              reg_write_en,
  output logic [ADDR_W-1:0] reg_write_dest,
  output logic [DATA_W-1:0] reg_write_data,
  output logic              wb_unexpected
);

  localparam int unsigned NREG = 2 ** ADDR_W;

  typedef enum logic {PrioAlu, PrioMem} prio_e;

  prio_e             prio_q, prio_d;
  logic [NREG-1:0]   busy_q, busy_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_dest_q, wr_dest_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic              unexp_q, unexp_d;
  logic              alu_grant, mem_grant;

  // Readys are gated by rst_n so both stay low for the whole reset window.
  always_comb begin
    alu_grant = rst_n & alu_wb_valid & (~mem_wb_valid | (prio_q == PrioAlu));
    mem_grant = rst_n & mem_wb_valid & (~alu_wb_valid | (prio_q == PrioMem));
  end

  always_comb begin
    prio_d    = prio_q;
    wr_en_d   = alu_grant | mem_grant;
    wr_dest_d = wr_dest_q;
    wr_data_d = wr_data_q;
    if (alu_grant) begin
      wr_dest_d = alu_wb_dest;
      wr_data_d = alu_wb_data;
      prio_d    = PrioMem;
    end else if (mem_grant) begin
      wr_dest_d = mem_wb_dest;
      wr_data_d = mem_wb_data;
      prio_d    = PrioAlu;
    end

    // Order matters: mark overrides the write's clear, flush overrides both.
    busy_d = busy_q;
    if (wr_en_q) busy_d[wr_dest_q] = 1'b0;
    if (mark_en) busy_d[mark_addr] = 1'b1;
    if (flush)   busy_d = '0;

    unexp_d = unexp_q | (wr_en_q & ~busy_q[wr_dest_q]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_q    <= PrioAlu;
      busy_q    <= '0;
      wr_en_q   <= 1'b0;
      wr_dest_q <= '0;
      wr_data_q <= '0;
      unexp_q   <= 1'b0;
    end else begin
      prio_q    <= prio_d;
      busy_q    <= busy_d;
      wr_en_q   <= wr_en_d;
      wr_dest_q <= wr_dest_d;
      wr_data_q <= wr_data_d;
      unexp_q   <= unexp_d;
    end
  end

  assign alu_wb_ready   = alu_grant;
  assign mem_wb_ready   = mem_grant;
  assign hazard_stall   = busy_q[chk_addr_1] | busy_q[chk_addr_2];
  assign reg_write_en   = wr_en_q;
  assign reg_write_dest = wr_dest_q;
  assign reg_write_data = wr_data_q;
  assign wb_unexpected  = unexp_q;

endmodule
